// File: rtl/vga_display_engine_if.sv
// Pixel-memory read port and video output bundle for vga_display_engine.
// master = display engine, slave = memory/monitor side.
interface vga_display_engine_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 8
);
  logic              mode;
  logic [PIX_W-1:0]  mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              pix_ce;
  logic              h_sync;
  logic              v_sync;
  logic [PIX_W-1:0]  rgb;
  logic              blank_n;
  logic              sync_n;
  logic              frame_start;

  modport master (
    input  mode, mem_data,
    output mem_addr, pix_ce, h_sync, v_sync, rgb, blank_n, sync_n, frame_start
  );

  modport slave (
    output mode, mem_data,
    input  mem_addr, pix_ce, h_sync, v_sync, rgb, blank_n, sync_n, frame_start
  );
endinterface

// File: rtl/vga_display_engine.sv
// VGA timing generator with two framebuffer windows (row-major and transposed),
// fixed memory read latency and a flag pipeline that keeps all outputs aligned.
module vga_display_engine #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter logic        SYNC_POL = 1'b1,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned W0_W     = 320,
  parameter int unsigned W0_H     = 320,
  parameter int unsigned W0_BASE  = 204800,
  parameter int unsigned W1_W     = 640,
  parameter int unsigned W1_H     = 320,
  parameter int unsigned W1_BASE  = 0
) (
  input  logic clk,
  input  logic rst,
  vga_display_engine_if.master bus
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HS0   = H_SYNC + H_BP;
  localparam int unsigned VS0   = V_SYNC + V_BP;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HC_W  = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int unsigned VC_W  = (V_TOT > 1) ? $clog2(V_TOT) : 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic inw;
    logic fs;
  } flags_t;

  logic [DIV_W-1:0]  div;
  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic              mode_q;
  logic              pix_ce;
  logic [31:0]       hc32;
  logic [31:0]       vc32;
  logic [31:0]       x;
  logic [31:0]       y;
  logic [31:0]       addr_full;
  flags_t            cur;
  flags_t            pipe [MEM_LAT];
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  rgb_q;
  logic              hs_q;
  logic              vs_q;
  logic              act_q;
  logic              fs_q;

  assign pix_ce = ~rst & (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (pix_ce) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // The window select is latched at the top-left tick so a frame never mixes windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      mode_q <= 1'b0;
    end else if (pix_ce) begin
      if (hc == HC_W'(H_TOT - 1)) begin
        hc <= '0;
        vc <= (vc == VC_W'(V_TOT - 1)) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
      if (hc == '0 && vc == '0) begin
        mode_q <= bus.mode;
      end
    end
  end

  always_comb begin
    hc32      = 32'(hc);
    vc32      = 32'(vc);
    x         = hc32 - HS0;
    y         = vc32 - VS0;
    cur       = '0;
    cur.hs    = hc32 < H_SYNC;
    cur.vs    = vc32 < V_SYNC;
    cur.act   = (hc32 >= HS0) && (hc32 < HS0 + H_ACTIVE) &&
                (vc32 >= VS0) && (vc32 < VS0 + V_ACTIVE);
    cur.fs    = (hc == '0) && (vc == '0);
    addr_full = '0;
    if (mode_q) begin
      cur.inw   = cur.act && (x < W1_W) && (y < W1_H);
      addr_full = W1_BASE + x * W1_H + y;
    end else begin
      cur.inw   = cur.act && (x < W0_W) && (y < W0_H);
      addr_full = W0_BASE + y * W0_W + x;
    end
  end

  // pipe[MEM_LAT-1] is the pixel whose memory word arrives on this tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        pipe[i] <= '0;
      end
      addr_q <= '0;
      rgb_q  <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      act_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (pix_ce) begin
        pipe[0] <= cur;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
          pipe[i] <= pipe[i-1];
        end
        addr_q <= cur.inw ? addr_full[ADDR_W-1:0] : '0;
        hs_q   <= pipe[MEM_LAT-1].hs;
        vs_q   <= pipe[MEM_LAT-1].vs;
        act_q  <= pipe[MEM_LAT-1].act;
        rgb_q  <= pipe[MEM_LAT-1].inw ? bus.mem_data : '0;
        fs_q   <= pipe[MEM_LAT-1].fs;
      end
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.pix_ce      = pix_ce;
  assign bus.h_sync      = hs_q ? SYNC_POL : ~SYNC_POL;
  assign bus.v_sync      = vs_q ? SYNC_POL : ~SYNC_POL;
  assign bus.rgb         = rgb_q;
  assign bus.blank_n     = act_q;
  assign bus.sync_n      = 1'b0;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_display_engine.sv
// Randomised check of vga_display_engine against a pixel-position model that
// derives every output from the clock count since reset release.
module tb_vga_display_engine;

  localparam int CLK_DIV  = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 10;
  localparam int V_FP     = 1;
  localparam bit POL      = 1'b0;
  localparam int ADDR_W   = 8;
  localparam int PIX_W    = 8;
  localparam int MEM_LAT  = 2;
  localparam int W0_W     = 8;
  localparam int W0_H     = 6;
  localparam int W0_BASE  = 250;
  localparam int W1_W     = 16;
  localparam int W1_H     = 5;
  localparam int W1_BASE  = 3;
  localparam int H_TOT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int HS0      = H_SYNC + H_BP;
  localparam int VS0      = V_SYNC + V_BP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   e;
  int   total;
  int   bad;
  int   frame_mode [64];

  vga_display_engine_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  vga_display_engine #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .SYNC_POL(POL),
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MEM_LAT(MEM_LAT),
    .W0_W(W0_W), .W0_H(W0_H), .W0_BASE(W0_BASE),
    .W1_W(W1_W), .W1_H(W1_H), .W1_BASE(W1_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input int a);
    if (a == W0_BASE) return 8'hA5;
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Memory with one internal register: together with the engine's sampling tick
  // the word comes back MEM_LAT ticks after its address.
  logic [7:0] mem_q = '0;
  always @(posedge clk) if (bus.pix_ce) mem_q <= mem_fn(int'(bus.mem_addr));
  assign bus.mem_data = mem_q;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic pixel(input int q, output bit hs, output bit vs, output bit act,
                       output bit inw, output int addr);
    int hc, vc, x, y, m;
    hc   = q % H_TOT;
    vc   = (q / H_TOT) % V_TOT;
    x    = hc - HS0;
    y    = vc - VS0;
    m    = frame_mode[(q / FRAME) % 64];
    hs   = hc < H_SYNC;
    vs   = vc < V_SYNC;
    act  = x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE;
    addr = 0;
    if (m == 0) begin
      inw = act && x < W0_W && y < W0_H;
      if (inw) addr = (W0_BASE + y * W0_W + x) % (1 << ADDR_W);
    end else begin
      inw = act && x < W1_W && y < W1_H;
      if (inw) addr = (W1_BASE + x * W1_H + y) % (1 << ADDR_W);
    end
  endtask

  task automatic run_checks();
    int k, r, a, oa;
    bit hs, vs, act, inw, ce, fs;
    k  = rst ? 0 : e / CLK_DIV;
    ce = !rst && (e % CLK_DIV == CLK_DIV - 1);
    a  = 0;
    if (k >= 1) pixel(k - 1, hs, vs, act, inw, a);
    r   = k - 1 - MEM_LAT;
    hs  = 0; vs = 0; act = 0; inw = 0; oa = 0;
    if (r >= 0) pixel(r, hs, vs, act, inw, oa);
    fs = !rst && e > 0 && (e % CLK_DIV == 0) && r >= 0 && (r % FRAME == 0);
    check_val("pix_ce",      int'(bus.pix_ce),      int'(ce));
    check_val("mem_addr",    int'(bus.mem_addr),    a);
    check_val("h_sync",      int'(bus.h_sync),      int'(hs ? POL : !POL));
    check_val("v_sync",      int'(bus.v_sync),      int'(vs ? POL : !POL));
    check_val("blank_n",     int'(bus.blank_n),     int'(act));
    check_val("rgb",         int'(bus.rgb),         inw ? int'(mem_fn(oa)) : 0);
    check_val("sync_n",      int'(bus.sync_n),      0);
    check_val("frame_start", int'(bus.frame_start), int'(fs));
  endtask

  task automatic cycle(input bit release_rst);
    int kn;
    @(posedge clk);
    if (!rst) e++;
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    if ($urandom_range(0, 299) == 0) bus.mode = ~bus.mode;
    kn = (e + 1) / CLK_DIV;
    if (!rst && ((e + 1) % CLK_DIV == 0) && ((kn - 1) % FRAME == 0))
      frame_mode[((kn - 1) / FRAME) % 64] = int'(bus.mode);
    #1 run_checks();
  endtask

  initial begin
    bus.mode = 1'b0;
    e     = 0;
    total = 0;
    bad   = 0;
    foreach (frame_mode[i]) frame_mode[i] = 0;

    repeat (3) cycle(1'b0);
    cycle(1'b1);
    repeat (2300) cycle(1'b0);

    // asynchronous reset in the middle of a line
    repeat ($urandom_range(3, 20)) cycle(1'b0);
    @(negedge clk);
    rst = 1'b1;
    e   = 0;
    #1 run_checks();
    bus.mode = 1'b1;
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    repeat (2300) cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
